// File: rtl/ram_read_data_pkg.sv
// Shared types and constants for the RAM read-burst engine.
package ram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam int unsigned MAX_RD_LATENCY = 4;

  // A full-length burst holds 2^size_len beats, so counters need one extra bit.
  function automatic int unsigned beat_cnt_width(input int unsigned size_len);
    return size_len + 1;
  endfunction

endpackage

// File: rtl/ram_read_data_if.sv
// Request, RAM read-port and result signals of the read-burst engine.
interface ram_read_data_if #(
  parameter int unsigned SIZE_DATA = 8,
  parameter int unsigned SIZE_ADDR = 4,
  parameter int unsigned SIZE_LEN  = 4
);
  logic                 i_rd_en;
  logic [SIZE_ADDR-1:0] i_addr;
  logic [SIZE_LEN-1:0]  i_len;
  logic                 o_ram_rd_en;
  logic [SIZE_ADDR-1:0] o_ram_addr;
  logic [SIZE_DATA-1:0] i_ram_data;
  logic [SIZE_DATA-1:0] o_data_rd;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_done;

  modport slave (
    input  i_rd_en, i_addr, i_len, i_ram_data,
    output o_ram_rd_en, o_ram_addr, o_data_rd, o_valid, o_busy, o_done
  );

  modport master (
    output i_rd_en, i_addr, i_len, i_ram_data,
    input  o_ram_rd_en, o_ram_addr, o_data_rd, o_valid, o_busy, o_done
  );
endinterface

// File: rtl/ram_rd_lat_pipe.sv
// Delay line marking which cycles carry valid RAM read data.
module ram_rd_lat_pipe #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_issue,
  output logic o_capture
);
  logic [RD_LATENCY-1:0] pipe_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= i_issue;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign o_capture = pipe_q[RD_LATENCY-1];
endmodule

// File: rtl/ram_read_data.sv
// Burst reader: issues incrementing RAM reads and captures each returned word.
module ram_read_data
  import ram_rd_pkg::*;
#(
  parameter int unsigned SIZE_DATA  = 8,
  parameter int unsigned SIZE_ADDR  = 4,
  parameter int unsigned SIZE_LEN   = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic            i_clk,
  input logic            i_rst_n,
  ram_read_data_if.slave bus
);
  localparam int unsigned CNT_W = beat_cnt_width(SIZE_LEN);
  localparam int unsigned LAT   = (RD_LATENCY < 1) ? 1 :
                                  (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;

  rd_state_e            state;
  logic [SIZE_ADDR-1:0] addr_q;
  logic [CNT_W-1:0]     beats_q;
  logic [CNT_W-1:0]     iss_cnt;
  logic [CNT_W-1:0]     ret_cnt;
  logic [SIZE_DATA-1:0] data_q;
  logic                 ram_rd_en_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 capture;

  ram_rd_lat_pipe #(.RD_LATENCY(LAT)) u_lat_pipe (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_issue   (ram_rd_en_q),
    .o_capture (capture)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      beats_q     <= '0;
      iss_cnt     <= '0;
      ret_cnt     <= '0;
      data_q      <= '0;
      ram_rd_en_q <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Return side runs independently of the issue counter.
      valid_q <= capture;
      if (capture) begin
        data_q  <= bus.i_ram_data;
        ret_cnt <= ret_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (bus.i_rd_en) begin
            state       <= ISSUE;
            addr_q      <= bus.i_addr;
            beats_q     <= CNT_W'(bus.i_len) + CNT_W'(1);
            iss_cnt     <= CNT_W'(1);
            ret_cnt     <= '0;
            ram_rd_en_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ISSUE: begin
          if (iss_cnt == beats_q) begin
            ram_rd_en_q <= 1'b0;
            state       <= DRAIN;
          end else begin
            addr_q  <= addr_q + SIZE_ADDR'(1);
            iss_cnt <= iss_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (ret_cnt == beats_q) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ram_rd_en = ram_rd_en_q;
  assign bus.o_ram_addr  = addr_q;
  assign bus.o_data_rd   = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
endmodule

// File: tb/tb_ram_read_data.sv
// Directed bench for ram_read_data: latency 1 and latency 3 instances, each with a RAM model holding mem[k]=0xA0+k.
module tb_ram_read_data;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ram_read_data_if #(.SIZE_DATA(8), .SIZE_ADDR(4), .SIZE_LEN(4)) bus0 ();
  ram_read_data_if #(.SIZE_DATA(8), .SIZE_ADDR(4), .SIZE_LEN(4)) bus1 ();

  ram_read_data #(.SIZE_DATA(8), .SIZE_ADDR(4), .SIZE_LEN(4), .RD_LATENCY(1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0)
  );
  ram_read_data #(.SIZE_DATA(8), .SIZE_ADDR(4), .SIZE_LEN(4), .RD_LATENCY(3)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1)
  );

  logic [7:0] mem [0:15];
  logic [7:0] ram0_q;
  logic [7:0] ram1_q [0:2];

  initial for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);

  // Idle RAM cycles return 0x5A so a stray capture is visible.
  always @(posedge clk) begin
    ram0_q    <= bus0.o_ram_rd_en ? mem[bus0.o_ram_addr] : 8'h5A;
    ram1_q[0] <= bus1.o_ram_rd_en ? mem[bus1.o_ram_addr] : 8'h5A;
    ram1_q[1] <= ram1_q[0];
    ram1_q[2] <= ram1_q[1];
  end
  assign bus0.i_ram_data = ram0_q;
  assign bus1.i_ram_data = ram1_q[2];

  logic       tr_rden  [0:31];
  logic       tr_valid [0:31];
  logic       tr_done  [0:31];
  logic       tr_busy  [0:31];
  logic [3:0] tr_addr  [0:31];
  logic [7:0] tr_data  [0:31];

  task automatic drive(input int sel, input logic en, input logic [3:0] a, input logic [3:0] l);
    if (sel == 0) begin
      bus0.i_rd_en = en; bus0.i_addr = a; bus0.i_len = l;
    end else begin
      bus1.i_rd_en = en; bus1.i_addr = a; bus1.i_len = l;
    end
  endtask

  task automatic sample(input int sel, input int k);
    if (sel == 0) begin
      tr_rden[k] = bus0.o_ram_rd_en; tr_addr[k] = bus0.o_ram_addr; tr_data[k] = bus0.o_data_rd;
      tr_valid[k] = bus0.o_valid; tr_done[k] = bus0.o_done; tr_busy[k] = bus0.o_busy;
    end else begin
      tr_rden[k] = bus1.o_ram_rd_en; tr_addr[k] = bus1.o_ram_addr; tr_data[k] = bus1.o_data_rd;
      tr_valid[k] = bus1.o_valid; tr_done[k] = bus1.o_done; tr_busy[k] = bus1.o_busy;
    end
  endtask

  // mode 0: one-cycle request; 1: extra request (addr 0) in cycle 2; 2: request held high.
  // Trace index k is cycle k, cycle 1 being the one after the accepting edge.
  task automatic run(input int sel, input logic [3:0] a, input logic [3:0] l, input int mode, input int ncyc);
    @(negedge clk);
    drive(sel, 1'b1, a, l);
    @(negedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      sample(sel, k);
      if (mode == 1 && k == 2) drive(sel, 1'b1, 4'h0, l);
      else if (mode != 2)      drive(sel, 1'b0, a, l);
      @(negedge clk);
    end
    drive(sel, 1'b0, a, l);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus0.o_ram_rd_en, bus0.o_ram_addr, bus0.o_data_rd, bus0.o_valid, bus0.o_busy, bus0.o_done} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_dut0: got %h exp 0000",
               {bus0.o_ram_rd_en, bus0.o_ram_addr, bus0.o_data_rd, bus0.o_valid, bus0.o_busy, bus0.o_done});
    end
    checks++;
    if ({bus1.o_ram_rd_en, bus1.o_ram_addr, bus1.o_data_rd, bus1.o_valid, bus1.o_busy, bus1.o_done} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_dut1: got %h exp 0000",
               {bus1.o_ram_rd_en, bus1.o_ram_addr, bus1.o_data_rd, bus1.o_valid, bus1.o_busy, bus1.o_done});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_beat();
    logic e;
    run(0, 4'h3, 4'h0, 0, 6);
    for (int k = 1; k <= 6; k++) begin
      e = (k == 1);
      checks++; if (tr_rden[k] !== e) begin failures++; $display("FAIL single_rden c%0d: got %b exp %b", k, tr_rden[k], e); end
      e = (k == 3);
      checks++; if (tr_valid[k] !== e) begin failures++; $display("FAIL single_valid c%0d: got %b exp %b", k, tr_valid[k], e); end
      e = (k == 4);
      checks++; if (tr_done[k] !== e) begin failures++; $display("FAIL single_done c%0d: got %b exp %b", k, tr_done[k], e); end
      e = (k <= 4);
      checks++; if (tr_busy[k] !== e) begin failures++; $display("FAIL single_busy c%0d: got %b exp %b", k, tr_busy[k], e); end
      if (k >= 3) begin
        checks++; if (tr_data[k] !== 8'hA3) begin failures++; $display("FAIL single_data c%0d: got %h exp a3", k, tr_data[k]); end
      end
    end
    checks++; if (tr_addr[1] !== 4'h3) begin failures++; $display("FAIL single_addr: got %h exp 3", tr_addr[1]); end
  endtask

  task automatic test_burst4();
    logic e;
    logic [3:0] ea;
    run(0, 4'h5, 4'h3, 0, 9);
    for (int k = 1; k <= 9; k++) begin
      e = (k <= 4);
      checks++; if (tr_rden[k] !== e) begin failures++; $display("FAIL burst4_rden c%0d: got %b exp %b", k, tr_rden[k], e); end
      if (k <= 4) begin
        ea = 4'h5 + 4'(k - 1);
        checks++; if (tr_addr[k] !== ea) begin failures++; $display("FAIL burst4_addr c%0d: got %h exp %h", k, tr_addr[k], ea); end
      end
      e = (k >= 3 && k <= 6);
      checks++; if (tr_valid[k] !== e) begin failures++; $display("FAIL burst4_valid c%0d: got %b exp %b", k, tr_valid[k], e); end
      if (k >= 3 && k <= 6) begin
        ea = 4'h5 + 4'(k - 3);
        checks++; if (tr_data[k] !== {4'hA, ea}) begin failures++; $display("FAIL burst4_data c%0d: got %h exp %h", k, tr_data[k], {4'hA, ea}); end
      end
      e = (k == 7);
      checks++; if (tr_done[k] !== e) begin failures++; $display("FAIL burst4_done c%0d: got %b exp %b", k, tr_done[k], e); end
      e = (k <= 7);
      checks++; if (tr_busy[k] !== e) begin failures++; $display("FAIL burst4_busy c%0d: got %b exp %b", k, tr_busy[k], e); end
    end
    checks++; if (tr_data[9] !== 8'hA8) begin failures++; $display("FAIL burst4_hold: got %h exp a8", tr_data[9]); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_a [0:2];
    logic [7:0] exp_d [0:2];
    exp_a[0] = 4'hE; exp_a[1] = 4'hF; exp_a[2] = 4'h0;
    exp_d[0] = 8'hAE; exp_d[1] = 8'hAF; exp_d[2] = 8'hA0;
    run(0, 4'hE, 4'h2, 0, 7);
    for (int j = 0; j < 3; j++) begin
      checks++; if (tr_addr[j+1] !== exp_a[j]) begin failures++; $display("FAIL wrap_addr beat%0d: got %h exp %h", j, tr_addr[j+1], exp_a[j]); end
      checks++; if (tr_valid[j+3] !== 1'b1 || tr_data[j+3] !== exp_d[j]) begin
        failures++; $display("FAIL wrap_data beat%0d: got v=%b d=%h exp v=1 d=%h", j, tr_valid[j+3], tr_data[j+3], exp_d[j]);
      end
    end
    checks++; if (tr_rden[4] !== 1'b0) begin failures++; $display("FAIL wrap_rden_end: got %b exp 0", tr_rden[4]); end
    checks++; if (tr_done[6] !== 1'b1 || tr_done[5] !== 1'b0) begin
      failures++; $display("FAIL wrap_done: got c5=%b c6=%b exp c5=0 c6=1", tr_done[5], tr_done[6]);
    end
  endtask

  task automatic test_ignored_request();
    int n_rden, n_valid, n_done;
    n_rden = 0; n_valid = 0; n_done = 0;
    run(0, 4'h9, 4'h3, 1, 12);
    for (int k = 1; k <= 12; k++) begin
      n_rden  += int'(tr_rden[k]);
      n_valid += int'(tr_valid[k]);
      n_done  += int'(tr_done[k]);
    end
    checks++; if (n_rden != 4) begin failures++; $display("FAIL ignored_rden_count: got %0d exp 4", n_rden); end
    checks++; if (n_valid != 4) begin failures++; $display("FAIL ignored_valid_count: got %0d exp 4", n_valid); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL ignored_done_count: got %0d exp 1", n_done); end
    checks++; if (tr_addr[4] !== 4'hC || tr_data[6] !== 8'hAC) begin
      failures++; $display("FAIL ignored_last_beat: got a=%h d=%h exp a=c d=ac", tr_addr[4], tr_data[6]);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    run(0, 4'h2, 4'h0, 2, 8);
    for (int k = 1; k <= 8; k++) begin
      e = (k == 1 || k == 6);
      checks++; if (tr_rden[k] !== e) begin failures++; $display("FAIL b2b_rden c%0d: got %b exp %b", k, tr_rden[k], e); end
      e = (k == 3 || k == 8);
      checks++; if (tr_valid[k] !== e) begin failures++; $display("FAIL b2b_valid c%0d: got %b exp %b", k, tr_valid[k], e); end
    end
    checks++; if (tr_busy[5] !== 1'b0 || tr_done[4] !== 1'b1) begin
      failures++; $display("FAIL b2b_gap: got busy5=%b done4=%b exp busy5=0 done4=1", tr_busy[5], tr_done[4]);
    end
    checks++; if (tr_data[8] !== 8'hA2) begin failures++; $display("FAIL b2b_data: got %h exp a2", tr_data[8]); end
  endtask

  task automatic test_reset_mid_burst();
    int stray;
    stray = 0;
    @(negedge clk);
    drive(0, 1'b1, 4'h0, 4'h7);
    @(negedge clk);
    drive(0, 1'b0, 4'h0, 4'h7);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus0.o_ram_rd_en, bus0.o_ram_addr, bus0.o_data_rd, bus0.o_valid, bus0.o_busy, bus0.o_done} !== 16'h0000) begin
      failures++;
      $display("FAIL midrst_outputs: got %h exp 0000",
               {bus0.o_ram_rd_en, bus0.o_ram_addr, bus0.o_data_rd, bus0.o_valid, bus0.o_busy, bus0.o_done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus0.o_valid !== 1'b0 || bus0.o_done !== 1'b0 || bus0.o_busy !== 1'b0 || bus0.o_ram_rd_en !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL midrst_quiet: got %0d active cycles exp 0", stray); end
    run(0, 4'h1, 4'h0, 0, 5);
    checks++; if (tr_valid[3] !== 1'b1 || tr_data[3] !== 8'hA1) begin
      failures++; $display("FAIL midrst_reread: got v=%b d=%h exp v=1 d=a1", tr_valid[3], tr_data[3]);
    end
    checks++; if (tr_done[4] !== 1'b1) begin failures++; $display("FAIL midrst_done: got %b exp 1", tr_done[4]); end
  endtask

  task automatic test_latency_sweep();
    logic e;
    logic [3:0] ea;
    run(1, 4'h5, 4'h3, 0, 11);
    for (int k = 1; k <= 11; k++) begin
      e = (k <= 4);
      checks++; if (tr_rden[k] !== e) begin failures++; $display("FAIL lat3_rden c%0d: got %b exp %b", k, tr_rden[k], e); end
      e = (k >= 5 && k <= 8);
      checks++; if (tr_valid[k] !== e) begin failures++; $display("FAIL lat3_valid c%0d: got %b exp %b", k, tr_valid[k], e); end
      if (k >= 5 && k <= 8) begin
        ea = 4'h5 + 4'(k - 5);
        checks++; if (tr_data[k] !== {4'hA, ea}) begin failures++; $display("FAIL lat3_data c%0d: got %h exp %h", k, tr_data[k], {4'hA, ea}); end
      end
      e = (k == 9);
      checks++; if (tr_done[k] !== e) begin failures++; $display("FAIL lat3_done c%0d: got %b exp %b", k, tr_done[k], e); end
      e = (k <= 9);
      checks++; if (tr_busy[k] !== e) begin failures++; $display("FAIL lat3_busy c%0d: got %b exp %b", k, tr_busy[k], e); end
    end
  endtask

  initial begin
    drive(0, 1'b0, 4'h0, 4'h0);
    drive(1, 1'b0, 4'h0, 4'h0);
    test_reset();
    test_single_beat();
    test_burst4();
    test_wrap();
    test_ignored_request();
    test_back_to_back();
    test_reset_mid_burst();
    test_latency_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
